// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - memory and decode handshake bundle for the fetch queue
//
// Purpose: groups the redirect input, the instruction-memory req/ack channel
// and the decode valid/ready channel into one interface.
// Modports:
//   master - the fetch queue side (drives mem_req/mem_addr and the decode outputs)
//   slave  - the environment side (memory, branch unit, decode)
// Signals:
//   redirect, redirect_pc           flush and restart fetch at redirect_pc
//   mem_req, mem_addr               fetch request and its address
//   mem_ack, mem_rdata              request completion and instruction word
//   instr, instr_pc, instr_valid    head-of-queue entry presented to decode
//   instr_ready                     decode consumes the head entry
//   count                           current queue occupancy
interface fetch_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  mem_req;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [CW-1:0]         count;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr, instr_pc, instr_valid, count
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr, instr_pc, instr_valid, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with req/ack memory fetch
//
// Purpose: issues sequential word fetches to a variable-latency instruction
// memory, buffers {instruction, pc} pairs in a circular queue and presents the
// head entry to decode. A redirect flushes the queue and restarts fetch.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_queue_if.master (redirect, memory req/ack, decode valid/ready, count)
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]         FULL = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] WORD = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] fpc, fpc_next;
  logic [DATA_WIDTH-1:0] req_addr, req_addr_next;
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] q_instr [DEPTH];
  logic [DATA_WIDTH-1:0] q_pc    [DEPTH];

  logic                  pop;
  logic                  push;
  logic [CW-1:0]         count_after_pop;
  logic [CW-1:0]         count_after_push;

  // A request is outstanding in both REQ and DROP; DROP only differs in
  // discarding the returned word.
  assign bus.mem_req  = (state == REQ) || (state == DROP);
  assign bus.mem_addr = req_addr;

  assign pop  = (count != '0) && bus.instr_ready;
  assign push = (state == REQ) && bus.mem_ack && !bus.redirect;

  // Occupancy seen by the issue decision includes this cycle's pop, so a
  // full queue being drained restarts fetch without a bubble.
  assign count_after_pop  = count - CW'(pop);
  assign count_after_push = count_after_pop + CW'(push);

  assign bus.instr       = q_instr[head];
  assign bus.instr_pc    = q_pc[head];
  assign bus.instr_valid = (count != '0);
  assign bus.count       = count;

  always_comb begin
    state_next    = state;
    fpc_next      = fpc;
    req_addr_next = req_addr;
    if (bus.redirect) begin
      fpc_next = bus.redirect_pc;
      case (state)
        IDLE: begin
          state_next    = REQ;
          req_addr_next = bus.redirect_pc;
        end
        REQ, DROP: begin
          if (bus.mem_ack) begin
            state_next    = REQ;
            req_addr_next = bus.redirect_pc;
          end else begin
            // The pending request must finish at its original address.
            state_next = DROP;
          end
        end
        default: state_next = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (count_after_pop < FULL) begin
            state_next    = REQ;
            req_addr_next = fpc;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            fpc_next = req_addr + WORD;
            if (count_after_push < FULL) begin
              req_addr_next = req_addr + WORD;
            end else begin
              state_next = IDLE;
            end
          end
        end
        DROP: begin
          if (bus.mem_ack) begin
            state_next    = REQ;
            req_addr_next = fpc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      req_addr <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state    <= state_next;
      fpc      <= fpc_next;
      req_addr <= req_addr_next;
      if (bus.redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count_after_push;
      end
    end
  end

  // Queue storage needs no reset; count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= bus.mem_rdata;
      q_pc[tail]    <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      assert (count != FULL);
    end
  end
endmodule
